// File: rtl/tick_bcd_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tick_bcd_counter_pkg
//  Description : Shared clock/counter constants: default digit count, BCD
//                digit width and the largest legal BCD digit value.
//  Revision    : 1.0 - initial release
// ============================================================================
package tick_bcd_counter_pkg;

    // Number of BCD digits the counter carries unless overridden
    localparam int c_ndig_default = 4;

    // Bits per BCD digit
    localparam int c_digit_w = 4;

    // Largest value a single BCD digit may hold
    localparam logic [c_digit_w-1:0] c_bcd_max = 4'd9;

    // Zero value of a single BCD digit
    localparam logic [c_digit_w-1:0] c_bcd_zero = 4'd0;

endpackage : tick_bcd_counter_pkg
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit
//  Description : One decade of the BCD counter. Steps up or down by one when
//                enabled, wrapping 9->0 / 0->9, and flags its extreme values
//                so the parent can build the ripple enables.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit
    import tick_bcd_counter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 up,
    output logic [c_digit_w-1:0] value,
    output logic                 at_max,
    output logic                 at_min
);

    logic [c_digit_w-1:0] value_q;
    logic [c_digit_w-1:0] value_d;

    // Next digit value: clear wins, otherwise step with BCD wrap. Any value
    // above 9 is treated as the wrap point so the digit always returns to range.
    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = c_bcd_zero;
        end else if (en) begin
            if (up) begin
                value_d = (value_q >= c_bcd_max) ? c_bcd_zero : value_q + 4'd1;
            end else begin
                value_d = ((value_q == c_bcd_zero) || (value_q > c_bcd_max))
                          ? c_bcd_max : value_q - 4'd1;
            end
        end
    end

    // Digit state register
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= c_bcd_zero;
        end else begin
            value_q <= value_d;
        end
    end

    assign value  = value_q;
    assign at_max = (value_q == c_bcd_max);
    assign at_min = (value_q == c_bcd_zero);

endmodule : bcd_digit
`default_nettype wire

// File: rtl/tick_bcd_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tick_bcd_counter
//  Description : NDIG-digit up/down BCD counter stepped by rising edges of a
//                divided clock that is sampled as data. Produces a one-cycle
//                tick per detected edge and a one-cycle terminal-count pulse
//                when the count wraps.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_bcd_counter
    import tick_bcd_counter_pkg::*;
#(
    parameter int NDIG = c_ndig_default
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mclk,
    input  logic                      run,
    input  logic                      up,
    input  logic                      clr,
    output logic [c_digit_w*NDIG-1:0] count,
    output logic                      tick,
    output logic                      tc
);

    // Delayed copy of mclk; resets high so an mclk already high when reset
    // is released cannot look like a fresh rising edge.
    logic mclk_d_q;
    logic mclk_d_d;
    logic tick_q;
    logic tick_d;
    logic tc_q;
    logic tc_d;

    logic            w_edge;
    logic            w_step;
    logic [NDIG-1:0] w_en;
    logic [NDIG-1:0] w_at_max;
    logic [NDIG-1:0] w_at_min;
    // w_low_max[i] / w_low_min[i]: every digit below i is at 9 / at 0
    logic [NDIG:0]   w_low_max;
    logic [NDIG:0]   w_low_min;

    assign w_edge = mclk & ~mclk_d_q;
    assign w_step = w_edge & run & ~clr;

    assign w_low_max[0] = 1'b1;
    assign w_low_min[0] = 1'b1;

    generate
        for (genvar i = 0; i < NDIG; i++) begin : g_digit
            assign w_low_max[i+1] = w_low_max[i] & w_at_max[i];
            assign w_low_min[i+1] = w_low_min[i] & w_at_min[i];
            assign w_en[i]        = w_step & (up ? w_low_max[i] : w_low_min[i]);

            bcd_digit u_digit (
                .clk    (clk),
                .rst    (rst),
                .clr    (clr),
                .en     (w_en[i]),
                .up     (up),
                .value  (count[c_digit_w*i +: c_digit_w]),
                .at_max (w_at_max[i]),
                .at_min (w_at_min[i])
            );
        end
    endgenerate

    // Next values for edge history, tick and wrap pulse; a wrap is a step
    // taken while every digit sits at the extreme in the step direction.
    always_comb begin
        mclk_d_d = mclk;
        tick_d   = w_edge;
        tc_d     = w_step & (up ? w_low_max[NDIG] : w_low_min[NDIG]);
    end

    // Edge history and registered pulse outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            mclk_d_q <= 1'b1;
            tick_q   <= 1'b0;
            tc_q     <= 1'b0;
        end else begin
            mclk_d_q <= mclk_d_d;
            tick_q   <= tick_d;
            tc_q     <= tc_d;
        end
    end

    assign tick = tick_q;
    assign tc   = tc_q;

endmodule : tick_bcd_counter
`default_nettype wire
